seg7_scan_n: RTL and testbench

Parametrised multiplexed seven-segment driver for N hex digits. A programmable prescaler sets the scan rate. Displayed data is double-buffered, so a frame is never torn. Adds per-digit decimal points, leading-zero blanking, per-digit blink and a frame strobe. Sits between the datapath and the board's common-anode display pins, replacing fixed 4-digit scanners.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_scan_n_if.sv | 23 ++
 rtl/seg7_hex_decode.sv | 22 ++
 rtl/seg7_scan_n.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_n.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: active-low glyph table,
// segment-off code, decimal-point bit position and the blink phase encoding.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;

    // Active-low {dp,g,f,e,d,c,b,a} glyphs; element 0 (rightmost) is hex 0.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_phase_e;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_n_if.sv
// Display-side bundle: digit data and per-digit controls in, scanned pin drive out.
// Master is the datapath that owns the digits; slave is the scanner.
interface seg7_scan_n_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   digit;
    logic [7:0]              seg;
    logic                    frame_tick;

    modport master (
        output data, dp_en, blink_mask, blank_lz,
        input  digit, seg, frame_tick
    );

    modport slave (
        input  data, dp_en, blink_mask, blank_lz,
        output digit, seg, frame_tick
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low segment code with optional decimal point and full blanking.
// Purely combinational, zero latency, no backpressure.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] code
);

    always_comb begin
        code = SEG_OFF;
        if (!blank) begin
            code = hex_to_seg(nibble);
            if (dp) begin
                code[DP_BIT] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_n.sv
// N-digit multiplexed seven-segment scanner with frame shadowing, blanking, blink and frame strobe.
// Digit and segment pins are registered and change together on each scan step; no backpressure.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic          clk,
    input  logic          rst,
    seg7_scan_n_if.slave  bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0]         PRESC_TC    = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FCNT_LAST   = FW'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_PIN = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            SEG_OFF_PIN = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    blink_phase_e          phase_q, phase_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic [7:0]            seg_q, seg_d;
    logic                  tick_q, tick_d;

    logic                  tc;
    logic                  frame_start;
    logic [3:0]            nib;
    logic                  dp_sel;
    logic                  blink_sel;
    logic                  lz_blank;
    logic                  hide;
    logic [7:0]            code;
    logic [NUM_DIGITS-1:0] onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= IDX_LAST;
            shadow_q <= '0;
            fcnt_q   <= '0;
            phase_q  <= BLINK_SHOW;
            digit_q  <= DIG_OFF_PIN;
            seg_q    <= SEG_OFF_PIN;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            fcnt_q   <= fcnt_d;
            phase_q  <= phase_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            tick_q   <= tick_d;
        end
    end

    assign tc          = (presc_q == PRESC_TC);
    assign frame_start = tc && (idx_d == '0);

    // Scan position: prescaler terminal count steps to the next digit.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (tc) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Frame bookkeeping: shadow capture, blink frame counter and strobe.
    always_comb begin
        shadow_d = shadow_q;
        fcnt_d   = fcnt_q;
        phase_d  = phase_q;
        tick_d   = frame_start;
        if (frame_start) begin
            shadow_d = bus.data;
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = (phase_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Digit 0 is shown on the very edge that captures the shadow, so it reads
    // the live bus; higher digits read the frozen frame value.
    always_comb begin
        logic hi_zero;
        nib       = bus.data[3:0];
        dp_sel    = bus.dp_en[0];
        blink_sel = bus.blink_mask[0];
        lz_blank  = 1'b0;
        hi_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero && (shadow_q[4*i +: 4] == 4'h0);
            if (idx_d == IW'(i)) begin
                nib       = shadow_q[4*i +: 4];
                dp_sel    = bus.dp_en[i];
                blink_sel = bus.blink_mask[i];
                lz_blank  = bus.blank_lz && hi_zero;
            end
        end
    end

    assign hide = lz_blank || (blink_sel && (phase_q == BLINK_HIDE));

    seg7_hex_decode u_decode (
        .nibble (nib),
        .dp     (dp_sel),
        .blank  (hide),
        .code   (code)
    );

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot[i] = (idx_d == IW'(i));
        end
    end

    always_comb begin
        digit_d = digit_q;
        seg_d   = seg_q;
        if (tc) begin
            digit_d = (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
            seg_d   = (SEG_ACTIVE_LOW != 0) ? code : ~code;
        end
    end

    assign bus.digit      = digit_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench: 4-digit active-low scanner (SCAN_DIV=4, BLINK_DIV=2) plus a
// 1-digit active-high instance with SCAN_DIV=2 for the boundary cases.
module tb_seg7_scan_n;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_n_if #(.NUM_DIGITS(4)) ifm ();
    seg7_scan_n_if #(.NUM_DIGITS(1)) if1 ();

    seg7_scan_n #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifm)
    );

    seg7_scan_n #(
        .NUM_DIGITS(1), .SCAN_DIV(2), .BLINK_DIV(1),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (ifm.frame_tick !== 1'b1 && n < budget);
        checks++;
        if (ifm.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame: frame_tick=%b after %0d cycles, required 1", ifm.frame_tick, n);
        end
    endtask

    task automatic test_reset();
        ifm.data = 16'h12AF;
        rst = 1'b1;
        #2;
        checks++;
        if (ifm.digit !== 4'b1111 || ifm.seg !== 8'hFF || ifm.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: digit=%b seg=%h tick=%b, required 1111 ff 0", ifm.digit, ifm.seg, ifm.frame_tick);
        end
        checks++;
        if (if1.digit !== 1'b0 || if1.seg !== 8'h00 || if1.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_active_high: digit=%b seg=%h tick=%b, required 0 00 0", if1.digit, if1.seg, if1.frame_tick);
        end
        steps(2);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ifm.digit !== 4'b1111 || ifm.seg !== 8'hFF) begin
                errors++;
                $display("FAIL reset_hold c%0d: digit=%b seg=%h, required 1111 ff", c, ifm.digit, ifm.seg);
            end
            if (c < 3) step();
        end
        step();
        checks++;
        if (ifm.digit !== 4'b1110 || ifm.seg !== 8'h8E || ifm.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL first_digit: digit=%b seg=%h tick=%b, required 1110 8e 1", ifm.digit, ifm.seg, ifm.frame_tick);
        end
        step();
        checks++;
        if (ifm.digit !== 4'b1110 || ifm.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: digit=%b tick=%b, required 1110 0", ifm.digit, ifm.frame_tick);
        end
        steps(3);
        checks++;
        if (ifm.digit !== 4'b1101 || ifm.seg !== 8'h88) begin
            errors++;
            $display("FAIL second_digit: digit=%b seg=%h, required 1101 88", ifm.digit, ifm.seg);
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] pat [4];
        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wait_frame(40);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (ifm.digit !== pat[(k / 4) % 4]) begin
                errors++;
                $display("FAIL scan_order k%0d: digit=%b, required %b", k, ifm.digit, pat[(k / 4) % 4]);
            end
            checks++;
            if (ifm.frame_tick !== ((k % 16) == 0)) begin
                errors++;
                $display("FAIL frame_tick k%0d: tick=%b, required %b", k, ifm.frame_tick, (k % 16) == 0);
            end
            step();
        end
    endtask

    task automatic test_shadow();
        wait_frame(40);
        ifm.data = 16'h1234;
        wait_frame(40);
        checks++;
        if (ifm.digit !== 4'b1110 || ifm.seg !== 8'h99) begin
            errors++;
            $display("FAIL shadow_d0: digit=%b seg=%h, required 1110 99", ifm.digit, ifm.seg);
        end
        steps(4);
        checks++;
        if (ifm.digit !== 4'b1101 || ifm.seg !== 8'hB0) begin
            errors++;
            $display("FAIL shadow_d1: digit=%b seg=%h, required 1101 b0", ifm.digit, ifm.seg);
        end
        ifm.data = 16'h5678;
        steps(4);
        checks++;
        if (ifm.digit !== 4'b1011 || ifm.seg !== 8'hA4) begin
            errors++;
            $display("FAIL shadow_d2: digit=%b seg=%h, required 1011 a4", ifm.digit, ifm.seg);
        end
        steps(4);
        checks++;
        if (ifm.digit !== 4'b0111 || ifm.seg !== 8'hF9) begin
            errors++;
            $display("FAIL shadow_d3: digit=%b seg=%h, required 0111 f9", ifm.digit, ifm.seg);
        end
        steps(4);
        checks++;
        if (ifm.digit !== 4'b1110 || ifm.seg !== 8'h80) begin
            errors++;
            $display("FAIL shadow_next: digit=%b seg=%h, required 1110 80", ifm.digit, ifm.seg);
        end
    endtask

    task automatic test_blank_lz();
        logic [7:0] exp_a [4];
        logic [7:0] exp_c [4];
        exp_a = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
        exp_c = '{8'h92, 8'hC0, 8'hF9, 8'hFF};
        ifm.blank_lz = 1'b1;
        ifm.data = 16'h0005;
        wait_frame(40);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ifm.seg !== exp_a[d]) begin
                errors++;
                $display("FAIL lz_0005 d%0d: seg=%h, required %h", d, ifm.seg, exp_a[d]);
            end
            if (d < 3) steps(4);
        end
        ifm.data = 16'h0000;
        wait_frame(40);
        checks++;
        if (ifm.seg !== 8'hC0) begin
            errors++;
            $display("FAIL lz_0000 d0: seg=%h, required c0", ifm.seg);
        end
        steps(4);
        checks++;
        if (ifm.seg !== 8'hFF) begin
            errors++;
            $display("FAIL lz_0000 d1: seg=%h, required ff", ifm.seg);
        end
        ifm.data = 16'h0105;
        wait_frame(40);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ifm.seg !== exp_c[d]) begin
                errors++;
                $display("FAIL lz_0105 d%0d: seg=%h, required %h", d, ifm.seg, exp_c[d]);
            end
            if (d < 3) steps(4);
        end
        ifm.blank_lz = 1'b0;
    endtask

    task automatic test_blink();
        logic [7:0] exp0;
        ifm.data       = 16'h0011;
        ifm.blink_mask = 4'b0001;
        ifm.dp_en      = 4'b0010;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int f = 0; f < 8; f++) begin
            exp0 = (((f / 2) % 2) == 0) ? 8'hF9 : 8'hFF;
            wait_frame(40);
            checks++;
            if (ifm.digit !== 4'b1110 || ifm.seg !== exp0) begin
                errors++;
                $display("FAIL blink_d0 f%0d: digit=%b seg=%h, required 1110 %h", f, ifm.digit, ifm.seg, exp0);
            end
            steps(4);
            checks++;
            if (ifm.digit !== 4'b1101 || ifm.seg !== 8'h79) begin
                errors++;
                $display("FAIL blink_dp_d1 f%0d: digit=%b seg=%h, required 1101 79", f, ifm.digit, ifm.seg);
            end
        end
        ifm.blink_mask = 4'b0000;
        ifm.dp_en      = 4'b0000;
    endtask

    task automatic test_rst_midframe();
        int n = 0;
        while (ifm.digit !== 4'b1011 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (ifm.digit !== 4'b1011) begin
            errors++;
            $display("FAIL wait_digit2: digit=%b, required 1011", ifm.digit);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ifm.digit !== 4'b1111 || ifm.seg !== 8'hFF || ifm.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL midframe_rst: digit=%b seg=%h tick=%b, required 1111 ff 0", ifm.digit, ifm.seg, ifm.frame_tick);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 1; c < 4; c++) begin
            step();
            checks++;
            if (ifm.digit !== 4'b1111) begin
                errors++;
                $display("FAIL restart_hold c%0d: digit=%b, required 1111", c, ifm.digit);
            end
        end
        step();
        checks++;
        if (ifm.digit !== 4'b1110 || ifm.seg !== 8'hF9 || ifm.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL restart_first: digit=%b seg=%h tick=%b, required 1110 f9 1", ifm.digit, ifm.seg, ifm.frame_tick);
        end
    endtask

    task automatic test_single_digit();
        int n = 0;
        while (if1.frame_tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (if1.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: tick=%b, required 1", if1.frame_tick);
        end
        if1.data = 4'h7;
        steps(2);
        checks++;
        if (if1.digit !== 1'b1 || if1.seg !== 8'h07 || if1.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL single_7: digit=%b seg=%h tick=%b, required 1 07 1", if1.digit, if1.seg, if1.frame_tick);
        end
        step();
        checks++;
        if (if1.seg !== 8'h07 || if1.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: seg=%h tick=%b, required 07 0", if1.seg, if1.frame_tick);
        end
        if1.data  = 4'hA;
        if1.dp_en = 1'b1;
        step();
        checks++;
        if (if1.seg !== 8'hF7 || if1.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL single_dp: seg=%h tick=%b, required f7 1", if1.seg, if1.frame_tick);
        end
        if1.data     = 4'h0;
        if1.dp_en    = 1'b0;
        if1.blank_lz = 1'b1;
        steps(2);
        checks++;
        if (if1.seg !== 8'h3F || if1.digit !== 1'b1) begin
            errors++;
            $display("FAIL single_zero: digit=%b seg=%h, required 1 3f", if1.digit, if1.seg);
        end
    endtask

    initial begin
        rst            = 1'b1;
        ifm.data       = 16'h0000;
        ifm.dp_en      = 4'b0000;
        ifm.blink_mask = 4'b0000;
        ifm.blank_lz   = 1'b0;
        if1.data       = 4'h0;
        if1.dp_en      = 1'b0;
        if1.blink_mask = 1'b0;
        if1.blank_lz   = 1'b0;
        test_reset();
        test_scan_order();
        test_shadow();
        test_blank_lz();
        test_blink();
        test_rst_midframe();
        test_single_digit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
